burst_memory: RTL and testbench
===============================

BURST_MEMORY -- requirements
Module: burst_memory

Interface
REQ-001 The module SHALL provide the parameter ADDR_WIDTH, default 32, defining the width of the byte address.
REQ-002 The module SHALL provide the parameter DEPTH_BYTES, default 1048576, giving the storage size in bytes; it SHALL be a power of two and a multiple of 4.
REQ-003 The module SHALL provide the parameter START_ADDR, default 32'h80020000, giving the byte address that maps to storage offset 0.
REQ-004 The module SHALL have the port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The module SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have the port address, input, ADDR_WIDTH bits: the burst base byte address.
REQ-007 The module SHALL have the port data_in, input, 32 bits: the write word.
REQ-008 The module SHALL have the port access_size, input, 2 bits: burst length, where 00=1, 01=4, 10=8 and 11=16 words.
REQ-009 The module SHALL have the port rw, input, 1 bit: 1 selects read, 0 selects write.
REQ-010 The module SHALL have the port enable, input, 1 bit: a transaction request.
REQ-011 The module SHALL have the port busy, output, 1 bit: a burst is in progress and further requests are ignored.
REQ-012 The module SHALL have the port data_out, output, 32 bits: the read word.
REQ-013 The module SHALL have the port data_valid, output, 1 bit: data_out holds a new read word this cycle.
REQ-014 The module SHALL have the port error, output, 1 bit: a one-cycle pulse flagging a rejected out-of-range request.

Function
REQ-015 The storage SHALL be byte-addressed and big-endian: the word at offset o is {mem[o], mem[o+1], mem[o+2], mem[o+3]}.
REQ-016 The offset SHALL be computed as address minus START_ADDR, with address[1:0] ignored, so that all accesses are word-aligned.
REQ-017 The FSM SHALL have two states, IDLE and BURST, and SHALL hold a captured base offset, rw, burst length N, and a word counter k.
REQ-018 A request SHALL be accepted on a rising edge where enable=1 and busy=0; address, rw and access_size are sampled only at acceptance.
REQ-019 On an accepted write, data_in SHALL be written as word 0 at the acceptance edge, and word k SHALL be written from data_in at the k-th edge thereafter, at offset base+4k.
REQ-020 On an accepted read, word 0 SHALL appear on data_out with data_valid=1 in the cycle following acceptance, and word k SHALL appear k cycles later; latency is 1 cycle, throughput is 1 word per cycle.
REQ-021 data_valid SHALL be high for exactly N consecutive cycles per read burst and SHALL be 0 for writes; data_out SHALL hold its last value when data_valid=0.
REQ-022 The FSM SHALL go from IDLE to BURST on acceptance when N>1, and SHALL stay in IDLE when N=1.
REQ-023 The FSM SHALL go from BURST to IDLE at the edge that transfers word N-1.
REQ-024 busy SHALL be 1 exactly while the FSM is in BURST (N-1 cycles), which permits back-to-back requests with no idle cycle.
REQ-025 While busy=1, the enable, address, rw and access_size inputs SHALL be ignored; data_in SHALL be sampled only on write-burst edges.
REQ-026 A read and a write to the same offset SHALL never coexist, because only one burst is active at a time.
REQ-027 The offset arithmetic SHALL be ADDR_WIDTH bits wide, unsigned.

Reset
REQ-028 When reset_n=0, the module SHALL asynchronously force the FSM to IDLE, k=0, busy=0, data_valid=0, error=0 and data_out=0.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 A reset asserted mid-burst SHALL abort the burst; words already written are retained and the remaining words are not written.
REQ-031 After reset_n deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-032 The module SHALL support the macro MEM_RANGE_CHECK_EN.
REQ-033 With MEM_RANGE_CHECK_EN defined, a request with address<START_ADDR or base+4N>DEPTH_BYTES SHALL be rejected: error=1 for one cycle, no write, data_valid=0, busy stays 0, and no state change.
REQ-034 Without MEM_RANGE_CHECK_EN, error SHALL be tied to 0 and each word offset SHALL be taken modulo DEPTH_BYTES, so bursts wrap from the last word to offset 0.

Verification
REQ-035 The bench SHALL cover a single-word write then read: write 0xDEADBEEF to 0x80020000 with size 00, then read the same address; the required response is data_out=0xDEADBEEF one cycle after acceptance, busy never high, and mem[0]=0xDE.
REQ-036 The bench SHALL cover a 4-word write burst: writing 0x11111111..0x44444444 to 0x80020010 with size 01 requires busy high for 3 cycles; a following 4-word read requires data_valid high for 4 cycles with the words in order.
REQ-037 The bench SHALL cover request blocking: enable held high during a 16-word read to 0x80020100, with address changed mid-burst, requires the change to be ignored and exactly 16 valid words from the original base, after which the next request is accepted at the edge busy falls.
REQ-038 The bench SHALL cover reset mid-burst: asserting reset_n=0 after the 3rd word of an 8-word write requires busy=0 and data_valid=0 immediately, words 0-2 present, and words 3-7 unchanged.
REQ-039 The bench SHALL cover the range check with MEM_RANGE_CHECK_EN: a read at 0x8001FFFC, or a 16-word read at START_ADDR+DEPTH_BYTES-32, requires an error pulse of 1 cycle, data_valid=0 and busy=0.
REQ-040 The bench SHALL cover wrap without MEM_RANGE_CHECK_EN: a 4-word write at START_ADDR+DEPTH_BYTES-8 requires words 2 and 3 to land at offsets 0 and 4, with error=0.

Source files
------------

// File: rtl/burst_memory.sv
// ---------------------------------------------------------------------------
// burst_memory
//   Byte-addressed, big-endian storage with single-word and fixed-length
//   burst access (1, 4, 8 or 16 words). A request is taken on a rising edge
//   with enable=1 while the block is not busy. Writes consume data_in from the
//   acceptance edge onward, one word per edge. Reads return one word per cycle
//   starting the cycle after acceptance.
//
//   Optional feature macro: MEM_RANGE_CHECK_EN
//     defined   : requests outside [START_ADDR, START_ADDR+DEPTH_BYTES) are
//                 rejected with a one-cycle error pulse.
//     undefined : error is tied low and word offsets wrap modulo DEPTH_BYTES.
//
//   Parameters
//     ADDR_WIDTH  - byte address width
//     DEPTH_BYTES - storage size in bytes (power of two, multiple of 4)
//     START_ADDR  - byte address that maps to storage offset 0
//
//   Ports
//     clock       in   clock, rising edge active
//     reset_n     in   asynchronous active-low reset (storage is not reset)
//     address     in   burst base byte address, bits [1:0] ignored
//     data_in     in   write word
//     access_size in   burst length: 00=1, 01=4, 10=8, 11=16 words
//     rw          in   1 = read, 0 = write
//     enable      in   transaction request
//     busy        out  burst in progress, requests ignored
//     data_out    out  read word, holds when data_valid=0
//     data_valid  out  data_out carries a new read word this cycle
//     error       out  one-cycle pulse for a rejected out-of-range request
// ---------------------------------------------------------------------------
module burst_memory #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DEPTH_BYTES = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = ADDR_WIDTH'(32'h80020000)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [31:0]           data_out,
    output logic                  data_valid,
    output logic                  error
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
    localparam int unsigned WORD_W = IDX_W - 2;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // Storage: byte array, never reset.
    logic [7:0] mem [DEPTH_BYTES];

    // FSM state and captured burst context.
    state_t            state_q, state_d;
    logic [WORD_W-1:0] base_q,  base_d;    // base word index
    logic              rw_q,    rw_d;
    logic [CNT_W-1:0]  last_q,  last_d;    // N-1
    logic [CNT_W-1:0]  k_q,     k_d;       // index of the word handled at the next edge

    // Request decode.
    logic [ADDR_WIDTH-1:0] aligned_c;
    logic [ADDR_WIDTH-1:0] req_off_c;
    logic [WORD_W-1:0]     req_word_c;
    logic [CNT_W-1:0]      req_last_c;
    logic                  accept_c;
    logic                  go_c;

    // Transfer controls for the current edge.
    logic                  wr_en_c;
    logic                  rd_en_c;
    logic [WORD_W-1:0]     word_idx_c;

    logic                  unused_bits;

    assign aligned_c  = {address[ADDR_WIDTH-1:2], 2'b00};
    assign req_off_c  = aligned_c - START_ADDR;
    // Low index bits of the offset give the modulo-DEPTH_BYTES word index.
    assign req_word_c = req_off_c[IDX_W-1:2];
    assign accept_c   = enable && (state_q == S_IDLE);

    // Burst length minus one from access_size.
    always_comb begin : decode_len
        req_last_c = '0;
        case (access_size)
            2'b00:   req_last_c = CNT_W'(0);
            2'b01:   req_last_c = CNT_W'(3);
            2'b10:   req_last_c = CNT_W'(7);
            default: req_last_c = CNT_W'(15);
        endcase
    end

`ifdef MEM_RANGE_CHECK_EN
    localparam int unsigned OFF_W = ADDR_WIDTH + 1;

    logic [OFF_W-1:0] end_c;
    logic             in_range_c;
    logic             reject_c;

    // One extra bit so base+4N cannot overflow near the top of the address space.
    assign end_c      = {1'b0, req_off_c} + OFF_W'({req_last_c, 2'b00}) + OFF_W'(4);
    assign in_range_c = (aligned_c >= START_ADDR) && (end_c <= OFF_W'(DEPTH_BYTES));
    assign go_c       = accept_c && in_range_c;
    assign reject_c   = accept_c && !in_range_c;

    // Rejection pulse, one cycle after the offending edge.
    always_ff @(posedge clock or negedge reset_n) begin : error_reg
        if (!reset_n) begin
            error <= 1'b0;
        end else begin
            error <= reject_c;
        end
    end
`else
    assign go_c  = accept_c;
    assign error = 1'b0;
`endif

    // Address bits [1:0] are ignored; upper offset bits drop out in the modulo index.
    assign unused_bits = ^{address[1:0], req_off_c};

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            rw_q    <= 1'b0;
            last_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rw_q    <= rw_d;
            last_q  <= last_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic: single-word requests never leave IDLE.
    always_comb begin : next_state
        state_d = state_q;
        base_d  = base_q;
        rw_d    = rw_q;
        last_d  = last_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    base_d = req_word_c;
                    rw_d   = rw;
                    last_d = req_last_c;
                    if (req_last_c != '0) begin
                        state_d = S_BURST;
                        k_d     = CNT_W'(1);
                    end
                end
            end
            S_BURST: begin
                if (k_q == last_q) begin
                    state_d = S_IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Output logic: word 0 is handled on the acceptance edge, later words in BURST.
    always_comb begin : output_dec
        wr_en_c    = 1'b0;
        rd_en_c    = 1'b0;
        word_idx_c = base_q + WORD_W'(k_q);
        case (state_q)
            S_IDLE: begin
                word_idx_c = req_word_c;
                wr_en_c    = go_c && !rw;
                rd_en_c    = go_c && rw;
            end
            S_BURST: begin
                wr_en_c = !rw_q;
                rd_en_c = rw_q;
            end
            default: begin
                wr_en_c = 1'b0;
                rd_en_c = 1'b0;
            end
        endcase
    end

    assign busy = (state_q == S_BURST);

    // Big-endian word write.
    always_ff @(posedge clock) begin : mem_write
        if (wr_en_c) begin
            mem[{word_idx_c, 2'b00}] <= data_in[31:24];
            mem[{word_idx_c, 2'b01}] <= data_in[23:16];
            mem[{word_idx_c, 2'b10}] <= data_in[15:8];
            mem[{word_idx_c, 2'b11}] <= data_in[7:0];
        end
    end

    // Registered big-endian read; data_out holds between read words.
    always_ff @(posedge clock or negedge reset_n) begin : read_reg
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_en_c;
            if (rd_en_c) begin
                data_out <= {mem[{word_idx_c, 2'b00}], mem[{word_idx_c, 2'b01}],
                             mem[{word_idx_c, 2'b10}], mem[{word_idx_c, 2'b11}]};
            end
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// ---------------------------------------------------------------------------
// tb_burst_memory
//   Directed and random bursts against a byte-level reference memory kept in
//   an associative array. Inputs are driven and outputs sampled on the falling
//   edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_burst_memory;

    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1048576;
    localparam logic [31:0] START = 32'h80020000;

    logic        clock;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [1:0]  access_size;
    logic        rw;
    logic        enable;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        error;

    int total = 0;
    int bad   = 0;

    bit   [7:0]  ref_mem [int unsigned];
    logic [31:0] wbuf [16];
    logic [31:0] last_rd;
    bit          last_known;

    burst_memory #(
        .ADDR_WIDTH (AW),
        .DEPTH_BYTES(DEPTH),
        .START_ADDR (START)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .enable     (enable),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int burst_len(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    // Storage offset of word k of a burst, wrapping at the storage size.
    function automatic int unsigned word_off(input logic [31:0] addr, input int k);
        logic [31:0] o;
        o = {addr[31:2], 2'b00} - START + 32'(4 * k);
        return o % DEPTH;
    endfunction

    function automatic bit ref_known(input int unsigned o);
        return ref_mem.exists(o) && ref_mem.exists(o + 1) &&
               ref_mem.exists(o + 2) && ref_mem.exists(o + 3);
    endfunction

    function automatic logic [31:0] ref_word(input int unsigned o);
        return {ref_mem[o], ref_mem[o + 1], ref_mem[o + 2], ref_mem[o + 3]};
    endfunction

    task automatic ref_write(input int unsigned o, input logic [31:0] w);
        ref_mem[o]     = w[31:24];
        ref_mem[o + 1] = w[23:16];
        ref_mem[o + 2] = w[15:8];
        ref_mem[o + 3] = w[7:0];
    endtask

    function automatic bit in_range(input logic [31:0] addr, input int n);
`ifdef MEM_RANGE_CHECK_EN
        longint unsigned a;
        a = longint'({addr[31:2], 2'b00});
        if (a < longint'(START)) return 1'b0;
        return (a - longint'(START) + longint'(4 * n)) <= longint'(DEPTH);
`else
        return (addr == addr) || (n == n);
`endif
    endfunction

    // One request from an idle falling edge. mode 0: quiet; mode 1: random
    // requests driven while busy; mode 2: enable held, address moved to alt at word 5.
    task automatic do_burst(input logic [31:0] addr, input logic [1:0] sz,
                            input logic is_read, input int mode, input logic [31:0] alt);
        int          n;
        int unsigned o;
        logic [31:0] exp;
        n           = burst_len(sz);
        enable      = 1'b1;
        address     = addr;
        access_size = sz;
        rw          = is_read;
        data_in     = wbuf[0];
        if (!in_range(addr, n)) begin
            @(posedge clock);
            @(negedge clock);
            enable = 1'b0;
            check("reject_error", 32'(error), 32'd1);
            check("reject_busy", 32'(busy), 32'd0);
            check("reject_valid", 32'(data_valid), 32'd0);
            @(negedge clock);
            check("reject_error_pulse", 32'(error), 32'd0);
            check("reject_busy_after", 32'(busy), 32'd0);
            return;
        end
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            o = word_off(addr, k);
            if (!is_read) ref_write(o, wbuf[k]);
            @(negedge clock);
            if (mode == 1 && k < n - 1) begin
                enable      = 1'b1;
                address     = START + 32'($urandom_range(0, 4095));
                rw          = 1'($urandom);
                access_size = 2'($urandom);
            end else if (mode == 2) begin
                if (k == 5) address = alt;
            end else begin
                enable = 1'b0;
            end
            data_in = (k + 1 < n) ? wbuf[k + 1] : $urandom;
            check("busy", 32'(busy), 32'(k < n - 1));
            check("data_valid", 32'(data_valid), 32'(is_read));
            check("error", 32'(error), 32'd0);
            if (is_read) begin
                if (ref_known(o)) begin
                    exp = ref_word(o);
                    check("data_out", data_out, exp);
                    last_rd    = exp;
                    last_known = 1'b1;
                end else begin
                    last_known = 1'b0;
                end
            end else if (last_known) begin
                check("data_out_hold", data_out, last_rd);
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = $urandom;
    endtask

    initial begin : stimulus
        logic [31:0] r;
        int unsigned o;

        reset_n     = 1'b0;
        enable      = 1'b0;
        address     = '0;
        data_in     = '0;
        access_size = 2'b00;
        rw          = 1'b0;
        last_rd     = '0;
        last_known  = 1'b1;
        for (int i = 0; i < 16; i++) wbuf[i] = '0;

        // Reset state.
        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_data_out", data_out, 32'd0);

        // First edge after release accepts a request.
        reset_n = 1'b1;

        // Single-word write then read.
        wbuf[0] = 32'hDEADBEEF;
        do_burst(START, 2'b00, 1'b0, 0, '0);
        check("mem0_byte", 32'(dut.mem[0]), 32'h000000DE);
        do_burst(START, 2'b00, 1'b1, 0, '0);

        // 4-word write and read back.
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h11111111 * 32'(i + 1);
        do_burst(START + 32'h10, 2'b01, 1'b0, 0, '0);
        do_burst(START + 32'h10, 2'b01, 1'b1, 0, '0);
        // Low address bits are ignored.
        do_burst(START + 32'h17, 2'b00, 1'b1, 0, '0);

        // Enable held through a 16-word read with the address changed mid-burst.
        fill_random(16);
        do_burst(START + 32'h100, 2'b11, 1'b0, 0, '0);
        fill_random(16);
        do_burst(START + 32'h200, 2'b11, 1'b0, 0, '0);
        do_burst(START + 32'h100, 2'b11, 1'b1, 2, START + 32'h200);
        do_burst(START + 32'h200, 2'b11, 1'b1, 0, '0);

        // Reset after the third word of an 8-word write.
        r = START + 32'h400;
        fill_random(8);
        do_burst(r, 2'b10, 1'b0, 0, '0);
        fill_random(8);
        enable      = 1'b1;
        address     = r;
        access_size = 2'b10;
        rw          = 1'b0;
        data_in     = wbuf[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            ref_write(word_off(r, k), wbuf[k]);
            @(negedge clock);
            enable  = 1'b0;
            data_in = wbuf[k + 1];
        end
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_data_out", data_out, 32'd0);
        last_rd    = '0;
        last_known = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        do_burst(r, 2'b10, 1'b1, 0, '0);

        // Last 8 words of storage.
        fill_random(8);
        do_burst(START + DEPTH - 32, 2'b10, 1'b0, 0, '0);
        do_burst(START + DEPTH - 32, 2'b10, 1'b1, 0, '0);

`ifdef MEM_RANGE_CHECK_EN
        // Below START_ADDR, and a 16-word burst running past the end.
        do_burst(32'h8001FFFC, 2'b00, 1'b1, 0, '0);
        do_burst(START + DEPTH - 32, 2'b11, 1'b1, 0, '0);
        fill_random(16);
        do_burst(START + DEPTH - 32, 2'b11, 1'b0, 0, '0);
        do_burst(START + DEPTH - 32, 2'b10, 1'b1, 0, '0);
`else
        // Burst wrapping from the last word to offset 0.
        fill_random(4);
        do_burst(START + DEPTH - 8, 2'b01, 1'b0, 0, '0);
        do_burst(START, 2'b00, 1'b1, 0, '0);
        do_burst(START + 32'h4, 2'b00, 1'b1, 0, '0);
        do_burst(START + DEPTH - 8, 2'b01, 1'b1, 0, '0);
`endif

        // Random traffic over a pre-filled window.
        for (int b = 0; b < 4; b++) begin
            fill_random(16);
            do_burst(START + 32'h800 + 32'(64 * b), 2'b11, 1'b0, 0, '0);
        end
        for (int it = 0; it < 40; it++) begin
            o = 32'h800 + 4 * $urandom_range(0, 48);
            r = START + o + 32'($urandom_range(0, 3));
            fill_random(16);
            do_burst(r, 2'($urandom), 1'($urandom), int'($urandom_range(0, 1)), '0);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clock);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_valid", 32'(data_valid), 32'd0);
            end
        end

        @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
